accel_op_scheduler: RTL and testbench

Round-robin command scheduler for the extended processor's accelerator units: activation, pooling, DMA, dot product, matrix multiply, max pooling, MAC and atomic memory. It accepts operation requests from up to NUM_REQ requesters (for example core, DMA engine, debug port). It grants one request at a time, pulses the start of the unit selected by the request's funct3, and waits for that unit's done. It then returns the unit's result to the granted requester through a valid/ready response channel. The block sits between the requesters and the shared accelerator units, so at most one unit operation is in flight.

---
 rtl/accel_op_scheduler.sv | 159 +++++++++++++++
 tb/tb_accel_op_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_op_scheduler.sv
// Round-robin scheduler: grants one accelerator request, pulses the selected unit's start, returns its result.
// Optional WAIT watchdog enabled by defining ACCEL_SCHED_TIMEOUT_EN.
module accel_op_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [3*NUM_REQ-1:0]   req_funct3,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    output logic [7:0]             unit_start,
    output logic [31:0]            unit_addr,
    input  logic [7:0]             unit_done,
    input  logic [255:0]           unit_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2:0]             rsp_id,
    output logic [31:0]            rsp_result,
    output logic                   rsp_timeout,
    output logic                   busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] result_q, result_d;
`ifdef ACCEL_SCHED_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
    logic        timeout_q, timeout_d;
`endif

    logic        gnt_found;
    logic [2:0]  gnt_idx;
    int          idx;

    // Rotating-priority search starting at rr_ptr_q.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        result_d = result_q;
`ifdef ACCEL_SCHED_TIMEOUT_EN
        timer_d   = timer_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    gnt_d   = gnt_idx;
                    sel_d   = req_funct3[3*int'(gnt_idx) +: 3];
                    addr_d  = req_addr[32*int'(gnt_idx) +: 32];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef ACCEL_SCHED_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done takes priority over a watchdog expiry in the same cycle.
                if (unit_done[sel_q]) begin
                    result_d = unit_result[32*int'(sel_q) +: 32];
`ifdef ACCEL_SCHED_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d  = S_RESP;
                end
`ifdef ACCEL_SCHED_TIMEOUT_EN
                else if (timer_q == TIMEOUT_CYCLES[15:0]) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
                timer_d = timer_q + 16'd1;
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (gnt_q == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_q + 3'd1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            sel_q    <= '0;
            addr_q   <= '0;
            result_q <= '0;
`ifdef ACCEL_SCHED_TIMEOUT_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            result_q <= result_d;
`ifdef ACCEL_SCHED_TIMEOUT_EN
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // rst gates the accept so it drops immediately, even with requests held.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && gnt_found && !rst) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        unit_start = '0;
        if (state_q == S_ISSUE) unit_start[sel_q] = 1'b1;
    end

    assign unit_addr  = addr_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = gnt_q;
    assign rsp_result = result_q;
    assign busy       = (state_q != S_IDLE);
`ifdef ACCEL_SCHED_TIMEOUT_EN
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_accel_op_scheduler.sv
// Directed bench for accel_op_scheduler: single op, wrong done, backpressure, reset in WAIT, fairness, watchdog.
module tb_accel_op_scheduler;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_funct3;
    logic [32*N-1:0] req_addr;
    logic [7:0]     unit_start;
    logic [31:0]    unit_addr;
    logic [7:0]     unit_done;
    logic [255:0]   unit_result;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2:0]     rsp_id;
    logic [31:0]    rsp_result;
    logic           rsp_timeout;
    logic           busy;

    logic [2:0]     f3 [N];
    logic [31:0]    ad [N];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_funct3 = '0;
        req_addr   = '0;
        for (int i = 0; i < N; i++) begin
            req_funct3[3*i +: 3] = f3[i];
            req_addr[32*i +: 32] = ad[i];
        end
    end

    accel_op_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .unit_start(unit_start), .unit_addr(unit_addr),
        .unit_done(unit_done), .unit_result(unit_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation with rsp_ready already high when done arrives.
    task automatic op(input logic [N-1:0] vmask, input int g, input logic [31:0] res, input string tag);
        logic [2:0] sel;
        sel = f3[g];
        req_valid = vmask;
        #1;
        check({tag, "_rdy"}, 64'(req_ready), 64'(1 << g));
        check({tag, "_onehot"}, 64'($countones(req_ready) <= 1), 64'd1);
        tick();
        check({tag, "_start"}, 64'(unit_start), 64'(1 << sel));
        check({tag, "_addr"}, 64'(unit_addr), 64'(ad[g]));
        check({tag, "_rdy_issue"}, 64'(req_ready), 64'd0);
        tick();
        unit_result[32*sel +: 32] = res;
        unit_done = 8'(1 << sel);
        rsp_ready = 1'b1;
        tick();
        unit_done = '0;
        check({tag, "_vld"}, 64'(rsp_valid), 64'd1);
        check({tag, "_id"}, 64'(rsp_id), 64'(g));
        check({tag, "_res"}, 64'(rsp_result), 64'(res));
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        unit_done = '0;
        rsp_ready = 1'b0;
        for (int n = 0; n < 8; n++) unit_result[32*n +: 32] = 32'hA000_0000 + n;
        f3[0] = 3'd5; f3[1] = 3'd0; f3[2] = 3'd3; f3[3] = 3'd4;
        ad[0] = 32'h200; ad[1] = 32'h300; ad[2] = 32'h100; ad[3] = 32'h400;

        // Reset state
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_unit_start", 64'(unit_start), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_unit_addr", 64'(unit_addr), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        rst = 1'b0;
        tick();

        // Single request from requester 2, unit 3, done after 5 WAIT cycles
        req_valid = 4'b0100;
        #1;
        check("single_rdy", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        check("single_start", 64'(unit_start), 64'h08);
        check("single_addr", 64'(unit_addr), 64'h100);
        check("single_busy", 64'(busy), 64'd1);
        tick();
        check("single_start_off", 64'(unit_start), 64'h00);
        tick(); tick(); tick(); tick();
        unit_result[32*3 +: 32] = 32'hDEAD_BEEF;
        unit_done = 8'h08;
        #1;
        check("single_no_comb_vld", 64'(rsp_valid), 64'd0);
        tick();
        unit_done = '0;
        check("single_vld", 64'(rsp_valid), 64'd1);
        check("single_id", 64'(rsp_id), 64'd2);
        check("single_res", 64'(rsp_result), 64'hDEAD_BEEF);
        check("single_to", 64'(rsp_timeout), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("single_idle", 64'(busy), 64'd0);

        // Wrong done: requester 3 selects unit 4; done in ISSUE and done[1] are ignored
        req_valid = 4'b1000;
        #1;
        check("wd_rdy", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        check("wd_start", 64'(unit_start), 64'h10);
        unit_result[32*4 +: 32] = 32'h77;
        unit_done = 8'h10;
        tick();
        unit_done = '0;
        check("wd_issue_done_ignored", 64'(rsp_valid), 64'd0);
        unit_result[32*1 +: 32] = 32'h99;
        unit_done = 8'h02;
        tick();
        unit_done = '0;
        check("wd_other_done_ignored", 64'(rsp_valid), 64'd0);
        check("wd_busy", 64'(busy), 64'd1);
        unit_result[32*4 +: 32] = 32'h55;
        unit_done = 8'h10;
        tick();
        unit_done = '0;
        check("wd_vld", 64'(rsp_valid), 64'd1);
        check("wd_res", 64'(rsp_result), 64'h55);
        check("wd_id", 64'(rsp_id), 64'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: requester 1, unit 0, rsp_ready low for 10 cycles
        req_valid = 4'b0010;
        #1;
        check("bp_rdy", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        tick();
        unit_result[31:0] = 32'h1234_5678;
        unit_done = 8'h01;
        tick();
        unit_done = '0;
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("bp_vld", 64'(rsp_valid), 64'd1);
            check("bp_id", 64'(rsp_id), 64'd1);
            check("bp_res", 64'(rsp_result), 64'h1234_5678);
            check("bp_no_rdy", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_next_grant", 64'(req_ready), 64'h4);
        req_valid = '0;
        #1;
        check("bp_idle", 64'(busy), 64'd0);

        // Reset asserted in WAIT; rr pointer must return to 0
        req_valid = 4'b1000;
        #1;
        check("rw_rdy", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("rw_in_wait", 64'(busy), 64'd1);
        req_valid = 4'b0100;
        #2;
        rst = 1'b1;
        #1;
        check("rw_busy", 64'(busy), 64'd0);
        check("rw_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rw_unit_start", 64'(unit_start), 64'd0);
        check("rw_req_ready", 64'(req_ready), 64'd0);
        check("rw_unit_addr", 64'(unit_addr), 64'd0);
        tick(); tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("rw_grant0", 64'(req_ready), 64'h1);

        // Fairness with all four requesters held valid
        op(4'b1111, 0, 32'hC0DE_0000, "fair0");
        op(4'b1111, 1, 32'hC0DE_0001, "fair1");
        op(4'b1111, 2, 32'hC0DE_0002, "fair2");
        op(4'b1111, 3, 32'hC0DE_0003, "fair3");
        op(4'b1111, 0, 32'hC0DE_0004, "fair4");
        req_valid = '0;

`ifdef ACCEL_SCHED_TIMEOUT_EN
        // Watchdog: requester 1 (unit 0) never completes
        unit_result[31:0] = 32'hFFFF_0000;
        req_valid = 4'b0010;
        #1;
        check("to_rdy", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        for (int k = 0; k < 40 && !rsp_valid; k++) tick();
        check("to_vld", 64'(rsp_valid), 64'd1);
        check("to_flag", 64'(rsp_timeout), 64'd1);
        check("to_res", 64'(rsp_result), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Done on the expiry cycle wins
        req_valid = 4'b0100;
        #1;
        check("tod_rdy", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        tick();
        for (int k = 0; k < 16; k++) tick();
        check("tod_not_early", 64'(rsp_valid), 64'd0);
        unit_result[32*3 +: 32] = 32'h77;
        unit_done = 8'h08;
        tick();
        unit_done = '0;
        check("tod_vld", 64'(rsp_valid), 64'd1);
        check("tod_flag", 64'(rsp_timeout), 64'd0);
        check("tod_res", 64'(rsp_result), 64'h77);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
